// File: rtl/dsp_mac_pkg.sv
// Shared definitions for the pre-add multiply-accumulate datapath: operation
// encodings and the signed saturation limits used by the accumulator.
package dsp_mac_pkg;

    typedef enum logic [1:0] {
        ModeLoad  = 2'b00,
        ModeAcc   = 2'b01,
        ModeSub   = 2'b10,
        ModeClear = 2'b11
    } mode_e;

    // Widest accumulator the limit helpers can describe.
    localparam int unsigned MaxAccW = 256;

    // Largest signed value of a w-bit word, as a zero-extended bit pattern.
    function automatic logic [MaxAccW-1:0] sat_max(input int unsigned w);
        logic [MaxAccW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MaxAccW; i++) begin
            if (i + 1 < w) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Most negative signed value of a w-bit word, as a zero-extended bit pattern.
    function automatic logic [MaxAccW-1:0] sat_min(input int unsigned w);
        logic [MaxAccW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MaxAccW; i++) begin
            if (i + 1 == w) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_preadd_mult_pipe.sv
// Operand capture plus PIPE_STAGES product stages forming M = B*(A+D); C, mode and
// a valid bit travel alongside the product so the accumulator sees them together.
module dsp_preadd_mult_pipe
    import dsp_mac_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned PIPE_STAGES = 2,
    parameter bit          NEGEDGE     = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     valid_i,
    input  mode_e                    mode_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    input  logic signed [DATA_W-1:0] c_i,
    input  logic signed [DATA_W-1:0] d_i,
    output logic                     valid_o,
    output mode_e                    mode_o,
    output logic signed [DATA_W-1:0] c_o,
    output logic signed [2*DATA_W:0] m_o
);

    typedef struct packed {
        logic              valid;
        mode_e             mode;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
        logic [DATA_W-1:0] d;
    } cap_t;

    typedef struct packed {
        logic              valid;
        mode_e             mode;
        logic [DATA_W-1:0] c;
        logic [2*DATA_W:0] m;
    } stage_t;

    cap_t                    cap_d, cap_q;
    stage_t [PIPE_STAGES-1:0] st_d, st_q;

    logic [DATA_W:0]   preadd;
    logic [2*DATA_W:0] preadd_ext, b_ext, prod;

    always_comb begin
        cap_d       = cap_q;
        cap_d.valid = valid_i;
        // Operands are only loaded for accepted operations to limit toggling.
        if (valid_i) begin
            cap_d.mode = mode_i;
            cap_d.a    = a_i;
            cap_d.b    = b_i;
            cap_d.c    = c_i;
            cap_d.d    = d_i;
        end

        preadd     = {cap_q.a[DATA_W-1], cap_q.a} + {cap_q.d[DATA_W-1], cap_q.d};
        preadd_ext = {{DATA_W{preadd[DATA_W]}}, preadd};
        b_ext      = {{(DATA_W+1){cap_q.b[DATA_W-1]}}, cap_q.b};
        // Both factors are sign-extended to the result width, so the low bits are exact.
        prod       = preadd_ext * b_ext;

        st_d[0].valid = cap_q.valid;
        st_d[0].mode  = cap_q.mode;
        st_d[0].c     = cap_q.c;
        st_d[0].m     = prod;
        for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
            st_d[i] = st_q[i-1];
        end
    end

    generate
        if (NEGEDGE) begin : g_fall
            always_ff @(negedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cap_q <= '0;
                    st_q  <= '0;
                end else begin
                    cap_q <= cap_d;
                    st_q  <= st_d;
                end
            end
        end else begin : g_rise
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cap_q <= '0;
                    st_q  <= '0;
                end else begin
                    cap_q <= cap_d;
                    st_q  <= st_d;
                end
            end
        end
    endgenerate

    assign valid_o = st_q[PIPE_STAGES-1].valid;
    assign mode_o  = st_q[PIPE_STAGES-1].mode;
    assign c_o     = st_q[PIPE_STAGES-1].c;
    assign m_o     = st_q[PIPE_STAGES-1].m;

endmodule

// File: rtl/dsp_mac_preadd_pipe.sv
// Pipelined pre-add multiply-accumulate: P is loaded, accumulated or decremented by
// B*(A+D) with wrap or saturation on overflow and a sticky overflow flag.
module dsp_mac_preadd_pipe
    import dsp_mac_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ACC_W       = 64,
    parameter int unsigned PIPE_STAGES = 2,
    parameter bit          NEGEDGE     = 1'b1,
    parameter bit          SATURATE    = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [1:0]               mode,
    input  logic signed [DATA_W-1:0] A,
    input  logic signed [DATA_W-1:0] B,
    input  logic signed [DATA_W-1:0] C,
    input  logic signed [DATA_W-1:0] D,
    output logic signed [ACC_W-1:0]  P,
    output logic                     out_valid,
    output logic                     ovf
);

    localparam logic [ACC_W-1:0] SatMax = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] SatMin = ACC_W'(sat_min(ACC_W));

    logic                     pipe_valid;
    mode_e                    pipe_mode;
    logic signed [DATA_W-1:0] pipe_c;
    logic signed [2*DATA_W:0] pipe_m;

    dsp_preadd_mult_pipe #(
        .DATA_W      (DATA_W),
        .PIPE_STAGES (PIPE_STAGES),
        .NEGEDGE     (NEGEDGE)
    ) u_mult (
        .clk_i   (clk),
        .rst_ni  (reset),
        .valid_i (in_valid),
        .mode_i  (mode_e'(mode)),
        .a_i     (A),
        .b_i     (B),
        .c_i     (C),
        .d_i     (D),
        .valid_o (pipe_valid),
        .mode_o  (pipe_mode),
        .c_o     (pipe_c),
        .m_o     (pipe_m)
    );

    logic signed [ACC_W-1:0] p_d, p_q;
    logic                    out_valid_d, out_valid_q;
    logic                    ovf_d, ovf_q;

    logic signed [ACC_W:0] c_ext, m_ext, p_ext, sum;
    logic                  ovf_hit;
    logic [ACC_W-1:0]      res;

    always_comb begin
        c_ext = (ACC_W+1)'(pipe_c);
        m_ext = (ACC_W+1)'(pipe_m);
        p_ext = (ACC_W+1)'(p_q);

        sum = '0;
        unique case (pipe_mode)
            ModeLoad:  sum = c_ext + m_ext;
            ModeAcc:   sum = p_ext + m_ext;
            ModeSub:   sum = p_ext - m_ext;
            ModeClear: sum = '0;
        endcase

        // One guard bit suffices: |M| never exceeds 2^(ACC_W-1).
        ovf_hit = sum[ACC_W] ^ sum[ACC_W-1];
        res     = sum[ACC_W-1:0];
        if (ovf_hit && SATURATE) begin
            res = sum[ACC_W] ? SatMin : SatMax;
        end

        p_d         = p_q;
        ovf_d       = ovf_q;
        out_valid_d = pipe_valid;
        if (pipe_valid) begin
            p_d   = res;
            ovf_d = (pipe_mode == ModeClear) ? 1'b0 : (ovf_q | ovf_hit);
        end
    end

    generate
        if (NEGEDGE) begin : g_fall
            always_ff @(negedge clk or negedge reset) begin
                if (!reset) begin
                    p_q         <= '0;
                    out_valid_q <= 1'b0;
                    ovf_q       <= 1'b0;
                end else begin
                    p_q         <= p_d;
                    out_valid_q <= out_valid_d;
                    ovf_q       <= ovf_d;
                end
            end
        end else begin : g_rise
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    p_q         <= '0;
                    out_valid_q <= 1'b0;
                    ovf_q       <= 1'b0;
                end else begin
                    p_q         <= p_d;
                    out_valid_q <= out_valid_d;
                    ovf_q       <= ovf_d;
                end
            end
        end
    endgenerate

    assign P         = p_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_dsp_mac_preadd_pipe.sv
// Bench for dsp_mac_preadd_pipe: wrapping and saturating instances share stimulus and
// are compared every cycle against a wide-integer model of the accumulator.
module tb_dsp_mac_preadd_pipe;
    import dsp_mac_pkg::*;

    localparam int PS  = 2;
    // Inputs driven after a rising edge appear at P one sample per (PS+1) falling edges + 1.
    localparam int LAT = PS + 2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0;
    logic [1:0]         mode = 2'b00;
    logic signed [31:0] A = '0, B = '0, C = '0, D = '0;
    logic signed [63:0] p_w, p_s;
    logic               out_valid_w, out_valid_s, ovf_w, ovf_s;

    always #5 clk = ~clk;

    dsp_mac_preadd_pipe #(.DATA_W(32), .ACC_W(64), .PIPE_STAGES(PS), .NEGEDGE(1'b1),
                          .SATURATE(1'b0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .mode(mode),
        .A(A), .B(B), .C(C), .D(D), .P(p_w), .out_valid(out_valid_w), .ovf(ovf_w)
    );

    dsp_mac_preadd_pipe #(.DATA_W(32), .ACC_W(64), .PIPE_STAGES(PS), .NEGEDGE(1'b1),
                          .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .mode(mode),
        .A(A), .B(B), .C(C), .D(D), .P(p_s), .out_valid(out_valid_s), .ovf(ovf_s)
    );

    typedef struct packed {
        logic               valid;
        logic [1:0]         mode;
        logic signed [31:0] a, b, c, d;
    } op_t;

    op_t                 q[$];
    logic signed [63:0]  mp[2];
    logic                mo[2];
    logic                ev;
    logic signed [127:0] lim_max, lim_min;
    int                  errors = 0;
    int                  checks = 0;

    // Index 0 models the wrapping instance, index 1 the saturating one.
    function automatic void model_apply(input op_t op);
        logic signed [127:0] a, b, c, d, m, p, r;
        a = 128'($signed(op.a));
        b = 128'($signed(op.b));
        c = 128'($signed(op.c));
        d = 128'($signed(op.d));
        m = (a + d) * b;
        for (int s = 0; s < 2; s++) begin
            p = 128'(mp[s]);
            if (op.mode == 2'b11) begin
                mp[s] = '0;
                mo[s] = 1'b0;
            end else begin
                if (op.mode == 2'b00)      r = c + m;
                else if (op.mode == 2'b01) r = p + m;
                else                       r = p - m;
                if (r > lim_max || r < lim_min) begin
                    mo[s] = 1'b1;
                    if (s == 1) mp[s] = (r < 0) ? lim_min[63:0] : lim_max[63:0];
                    else        mp[s] = r[63:0];
                end else begin
                    mp[s] = r[63:0];
                end
            end
        end
    endfunction

    task automatic tick();
        op_t op;
        @(posedge clk);
        ev = 1'b0;
        if (q.size() == LAT) begin
            op = q.pop_front();
            if (op.valid) begin
                ev = 1'b1;
                model_apply(op);
            end
        end
    endtask

    task automatic drive(input logic rst_n, input logic v, input logic [1:0] m,
                         input logic signed [31:0] a, input logic signed [31:0] b,
                         input logic signed [31:0] c, input logic signed [31:0] d);
        reset    = rst_n;
        in_valid = v;
        mode     = m;
        A = a; B = b; C = c; D = d;
        if (!rst_n) begin
            q.delete();
            mp[0] = '0; mp[1] = '0;
            mo[0] = 1'b0; mo[1] = 1'b0;
        end else begin
            q.push_back('{valid: v, mode: m, a: a, b: b, c: c, d: d});
        end
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 2'($urandom()), $urandom(), $urandom(), $urandom(), $urandom());
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, ModeLoad, $urandom(), $urandom(), $urandom(), $urandom());
            tick();
            checks++;
            if ({out_valid_w, ovf_w, p_w} !== 66'd0) begin
                errors++;
                $display("FAIL reset_wrap k=%0d: got v=%b ovf=%b P=%0d, want all zero",
                         k, out_valid_w, ovf_w, p_w);
            end
            checks++;
            if ({out_valid_s, ovf_s, p_s} !== 66'd0) begin
                errors++;
                $display("FAIL reset_sat k=%0d: got v=%b ovf=%b P=%0d, want all zero",
                         k, out_valid_s, ovf_s, p_s);
            end
        end
    endtask

    task automatic test_load_latency();
        int pulses = 0;
        int at = -1;
        for (int k = 0; k < 7; k++) begin
            if (k == 0) drive(1'b1, 1'b1, ModeLoad, 5, 2, 3, 4);
            else        idle();
            tick();
            checks++;
            if ({out_valid_w, ovf_w, p_w} !== {ev, mo[0], mp[0]}) begin
                errors++;
                $display("FAIL load_model k=%0d: got v=%b ovf=%b P=%0d, want v=%b ovf=%b P=%0d",
                         k, out_valid_w, ovf_w, p_w, ev, mo[0], mp[0]);
            end
            if (out_valid_w) begin
                pulses++;
                at = k;
            end
        end
        checks++;
        if (pulses != 1 || at != 3) begin
            errors++;
            $display("FAIL load_latency: got %0d pulses last at %0d, want 1 pulse at 3",
                     pulses, at);
        end
        checks++;
        if (p_w !== 64'sd21) begin
            errors++;
            $display("FAIL load_value: got P=%0d, want 21", p_w);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] md[5] = '{ModeLoad, ModeAcc, ModeAcc, ModeAcc, ModeSub};
        int         av[5] = '{5, 5, 5, 5, 1};
        int         bv[5] = '{2, 2, 2, 2, 10};
        int         dv[5] = '{4, 4, 4, 4, 0};
        longint     want[5] = '{21, 39, 57, 75, 65};
        int         idx = 0;
        for (int k = 0; k < 10; k++) begin
            if (k < 5) drive(1'b1, 1'b1, md[k], av[k], bv[k], (k == 0) ? 3 : $urandom(), dv[k]);
            else       idle();
            tick();
            checks++;
            if ({out_valid_w, ovf_w, p_w} !== {ev, mo[0], mp[0]}) begin
                errors++;
                $display("FAIL b2b_model k=%0d: got v=%b ovf=%b P=%0d, want v=%b ovf=%b P=%0d",
                         k, out_valid_w, ovf_w, p_w, ev, mo[0], mp[0]);
            end
            if (out_valid_w && idx < 5) begin
                checks++;
                if (p_w !== want[idx]) begin
                    errors++;
                    $display("FAIL b2b_value #%0d: got P=%0d, want %0d", idx, p_w, want[idx]);
                end
                idx++;
            end
        end
        checks++;
        if (idx != 5) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, want 5", idx);
        end
    endtask

    task automatic test_bubble();
        logic [7:0] vpat = '0;
        for (int k = 0; k < 8; k++) begin
            if (k == 0)      drive(1'b1, 1'b1, ModeLoad, 5, 2, 3, 4);
            else if (k == 2) drive(1'b1, 1'b1, ModeAcc, 1, 1, $urandom(), 1);
            else             idle();
            tick();
            vpat[k] = out_valid_w;
            checks++;
            if ({out_valid_w, ovf_w, p_w} !== {ev, mo[0], mp[0]}) begin
                errors++;
                $display("FAIL bubble_model k=%0d: got v=%b ovf=%b P=%0d, want v=%b ovf=%b P=%0d",
                         k, out_valid_w, ovf_w, p_w, ev, mo[0], mp[0]);
            end
            if (k == 4) begin
                checks++;
                if (p_w !== 64'sd21) begin
                    errors++;
                    $display("FAIL bubble_hold: got P=%0d, want 21", p_w);
                end
            end
        end
        checks++;
        if (vpat !== 8'b0010_1000 || p_w !== 64'sd23) begin
            errors++;
            $display("FAIL bubble_pattern: got valid=%b P=%0d, want 00101000 P=23", vpat, p_w);
        end
    endtask

    task automatic test_overflow();
        logic signed [31:0] mn = 32'sh8000_0000;
        logic [63:0] ew, es;
        logic        eo;
        for (int k = 0; k < 8; k++) begin
            if (k == 0)      drive(1'b1, 1'b1, ModeLoad, mn, mn, 0, mn);
            else if (k == 1) drive(1'b1, 1'b1, ModeAcc, 1, 1, $urandom(), 0);
            else if (k == 2) drive(1'b1, 1'b1, ModeClear, $urandom(), $urandom(), $urandom(),
                                   $urandom());
            else             idle();
            tick();
            checks++;
            if ({out_valid_w, ovf_w, p_w} !== {ev, mo[0], mp[0]}) begin
                errors++;
                $display("FAIL ovf_model_wrap k=%0d: got v=%b ovf=%b P=%0d, want v=%b ovf=%b P=%0d",
                         k, out_valid_w, ovf_w, p_w, ev, mo[0], mp[0]);
            end
            checks++;
            if ({out_valid_s, ovf_s, p_s} !== {ev, mo[1], mp[1]}) begin
                errors++;
                $display("FAIL ovf_model_sat k=%0d: got v=%b ovf=%b P=%0d, want v=%b ovf=%b P=%0d",
                         k, out_valid_s, ovf_s, p_s, ev, mo[1], mp[1]);
            end
            if (k >= 3 && k <= 5) begin
                case (k)
                    3:       begin ew = 64'h8000_0000_0000_0000; es = 64'h7fff_ffff_ffff_ffff; eo = 1'b1; end
                    4:       begin ew = 64'h8000_0000_0000_0001; es = 64'h7fff_ffff_ffff_ffff; eo = 1'b1; end
                    default: begin ew = '0; es = '0; eo = 1'b0; end
                endcase
                checks++;
                if ({ovf_w, p_w} !== {eo, ew} || {ovf_s, p_s} !== {eo, es}) begin
                    errors++;
                    $display("FAIL ovf_value k=%0d: got wrap ovf=%b P=%h sat ovf=%b P=%h, want ovf=%b wrap P=%h sat P=%h",
                             k, ovf_w, p_w, ovf_s, p_s, eo, ew, es);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 9; k++) begin
            if (k == 0)      drive(1'b1, 1'b1, ModeLoad, 5, 2, 3, 4);
            else if (k == 1) drive(1'b0, 1'b1, ModeLoad, $urandom(), $urandom(), $urandom(),
                                   $urandom());
            else             idle();
            tick();
            checks++;
            if ({out_valid_w, ovf_w, p_w} !== {ev, mo[0], mp[0]}) begin
                errors++;
                $display("FAIL rstmid_model k=%0d: got v=%b ovf=%b P=%0d, want v=%b ovf=%b P=%0d",
                         k, out_valid_w, ovf_w, p_w, ev, mo[0], mp[0]);
            end
            if (k >= 1) begin
                checks++;
                if (out_valid_w !== 1'b0 || p_w !== 64'sd0) begin
                    errors++;
                    $display("FAIL rstmid_flush k=%0d: got v=%b P=%0d, want v=0 P=0",
                             k, out_valid_w, p_w);
                end
            end
        end
    endtask

    task automatic test_random();
        logic signed [31:0] opv[4];
        for (int k = 0; k < 305; k++) begin
            for (int j = 0; j < 4; j++) begin
                if ($urandom_range(3) == 0) opv[j] = $urandom();
                else                        opv[j] = 32'($signed($urandom_range(200)) - 100);
            end
            if (k < 300) drive(1'b1, ($urandom_range(3) != 0), 2'($urandom()),
                               opv[0], opv[1], opv[2], opv[3]);
            else         idle();
            tick();
            checks++;
            if ({out_valid_w, ovf_w, p_w} !== {ev, mo[0], mp[0]}) begin
                errors++;
                $display("FAIL rand_wrap k=%0d: got v=%b ovf=%b P=%0d, want v=%b ovf=%b P=%0d",
                         k, out_valid_w, ovf_w, p_w, ev, mo[0], mp[0]);
            end
            checks++;
            if ({out_valid_s, ovf_s, p_s} !== {ev, mo[1], mp[1]}) begin
                errors++;
                $display("FAIL rand_sat k=%0d: got v=%b ovf=%b P=%0d, want v=%b ovf=%b P=%0d",
                         k, out_valid_s, ovf_s, p_s, ev, mo[1], mp[1]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        lim_max = 128'sd1;
        lim_max = (lim_max <<< 63) - 1;
        lim_min = -lim_max - 1;
        mp[0] = '0; mp[1] = '0;
        mo[0] = 1'b0; mo[1] = 1'b0;
        ev = 1'b0;

        test_reset();
        test_load_latency();
        test_back_to_back();
        test_bubble();
        test_overflow();
        test_reset_mid();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
